// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the Thumb fetch/decode/execute sequencer.
// Imported by the sequencer, its condition evaluator and its bus interface.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_t;

    localparam logic [4:0] UOP_STR   = 5'd9;
    localparam logic [4:0] UOP_LDR   = 5'd10;

    localparam logic [3:0] COND_EQ   = 4'h0;
    localparam logic [3:0] COND_NE   = 4'h1;
    localparam logic [3:0] COND_CS   = 4'h2;
    localparam logic [3:0] COND_CC   = 4'h3;
    localparam logic [3:0] COND_MI   = 4'h4;
    localparam logic [3:0] COND_PL   = 4'h5;
    localparam logic [3:0] COND_VS   = 4'h6;
    localparam logic [3:0] COND_VC   = 4'h7;
    localparam logic [3:0] COND_HI   = 4'h8;
    localparam logic [3:0] COND_LS   = 4'h9;
    localparam logic [3:0] COND_GE   = 4'hA;
    localparam logic [3:0] COND_LT   = 4'hB;
    localparam logic [3:0] COND_GT   = 4'hC;
    localparam logic [3:0] COND_LE   = 4'hD;
    localparam logic [3:0] COND_AL   = 4'hE;
    localparam logic [3:0] COND_NONE = 4'hF;

    function automatic logic is_mem_uop(input logic [4:0] uop);
        return (uop == UOP_STR) || (uop == UOP_LDR);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the sequencer and imem/decoder/datapath.
// master = sequencer side, slave = the surrounding core (or a bench).
interface pc_sequencer_if
    import seq_pkg::*;
#(
    parameter int ADDR_W = 32
);
    // Fetch: imem_req is high for every FETCH cycle; the cycle imem_ready is
    // seen with imem_req high transfers imem_rdata. Data side: dmem_req holds
    // until dmem_ready; that same cycle completes the access. Readies seen
    // while the matching request is low are ignored.
    logic              imem_req;
    logic              imem_ready;
    logic [15:0]       imem_rdata;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_q;
    logic [4:0]        uop;
    logic [3:0]        branch_cond;
    logic [31:0]       num;
    logic              explose;
    logic [3:0]        nzcv;
    logic              exec_en;
    logic              dmem_req;
    logic              dmem_ready;
    logic              branch_taken;
    logic              halted;
    seq_state_t        dbg_state;

    modport master (
        output imem_req, pc, instr_q, exec_en, dmem_req, branch_taken, halted, dbg_state,
        input  imem_ready, imem_rdata, uop, branch_cond, num, explose, nzcv, dmem_ready
    );

    modport slave (
        input  imem_req, pc, instr_q, exec_en, dmem_req, branch_taken, halted, dbg_state,
        output imem_ready, imem_rdata, uop, branch_cond, num, explose, nzcv, dmem_ready
    );

endinterface

// File: rtl/pc_sequencer_cond_eval.sv
// ARM condition-code evaluator: decides whether cond passes for flags {N,Z,C,V}.
// AL always passes; the "not a branch" code never does.
module cond_eval
    import seq_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);
    logic w_n, w_z, w_c, w_v;

    assign w_n = i_nzcv[3];
    assign w_z = i_nzcv[2];
    assign w_c = i_nzcv[1];
    assign w_v = i_nzcv[0];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer owning the Thumb PC and branch resolution.
// Define SEQ_PERF_EN to add the perf_retired / perf_taken event counters.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_sequencer_if.master       bus
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]          perf_retired,
    output logic [31:0]          perf_taken
`endif
);
    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_instr;
    logic              r_halted;

    logic              w_cond_pass;
    logic              w_taken;
    logic              w_exec_en;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_pc_br;
    logic              w_unused_num;

    cond_eval u_cond_eval (
        .i_cond (bus.branch_cond),
        .i_nzcv (bus.nzcv),
        .o_pass (w_cond_pass)
    );

    // Unconditional branches carry an 11-bit halfword offset, conditional ones 8 bits.
    always_comb begin
        w_off = '0;
        if (bus.branch_cond == COND_AL)
            w_off = {{(ADDR_W-12){bus.num[10]}}, bus.num[10:0], 1'b0};
        else
            w_off = {{(ADDR_W-9){bus.num[7]}}, bus.num[7:0], 1'b0};
    end

    assign w_pc_seq     = r_pc + ADDR_W'(2);
    assign w_pc_br      = r_pc + ADDR_W'(4) + w_off;
    assign w_taken      = (r_state == ST_EXEC) && (bus.branch_cond != COND_NONE) && w_cond_pass;
    assign w_exec_en    = (r_state == ST_EXEC) || ((r_state == ST_MEM) && bus.dmem_ready);
    assign w_unused_num = ^bus.num[31:11];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= 16'h0000;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.imem_ready) begin
                        r_instr <= bus.imem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (bus.explose) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else if (is_mem_uop(bus.uop)) begin
                        r_state  <= ST_MEM;
                    end else begin
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_pc    <= w_taken ? w_pc_br : w_pc_seq;
                    r_state <= ST_FETCH;
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        r_pc    <= w_pc_seq;
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Request strobes decode straight from state so an async reset drops them at once.
    assign bus.imem_req     = (r_state == ST_FETCH);
    assign bus.dmem_req     = (r_state == ST_MEM);
    assign bus.exec_en      = w_exec_en;
    assign bus.branch_taken = w_taken;
    assign bus.pc           = r_pc;
    assign bus.instr_q      = r_instr;
    assign bus.halted       = r_halted;
    assign bus.dbg_state    = r_state;

`ifdef SEQ_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_taken;

    // No strobes fire in HALT, so both counters freeze there without extra gating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_retired <= '0;
            r_perf_taken   <= '0;
        end else begin
            if (w_exec_en)
                r_perf_retired <= r_perf_retired + 32'd1;
            if (w_taken)
                r_perf_taken   <= r_perf_taken + 32'd1;
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_taken   = r_perf_taken;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table through a commit scoreboard,
// plus hand sequences for reset, first-commit latency, wrap, halt and reset-in-MEM.
module tb_pc_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

`ifdef SEQ_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_taken;
`endif

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SEQ_PERF_EN
        ,
        .perf_retired (perf_retired),
        .perf_taken   (perf_taken)
`endif
    );

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  uop;
        logic [3:0]  cond;
        logic [31:0] num;
        logic [3:0]  nzcv;
        int          dmem_wait;
        logic [31:0] exp_pc;
        logic        exp_taken;
        logic        exp_mem;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int exp_retired = 0;
    int exp_taken_cnt = 0;
    logic [33:0] exp_q[$];
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_retired   = 0;
        exp_taken_cnt = 0;
    endtask

    task automatic wait_fetch();
        int guard;
        guard = 0;
        while (!bus.imem_req && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("fetch_req_seen", 32'(bus.imem_req), 32'd1);
    endtask

    // Fetch one instruction, push its expected commit, then wait for exec_en and score it.
    task automatic run_vec(input vec_t v, input string tag);
        int guard;
        int dcyc;
        bit got;
        logic [33:0] e;
        wait_fetch();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.imem_rdata  = v.instr;
        bus.uop         = v.uop;
        bus.branch_cond = v.cond;
        bus.num         = v.num;
        bus.nzcv        = v.nzcv;
        bus.explose     = 1'b0;
        bus.imem_ready  = 1'b1;
        exp_q.push_back({v.exp_taken, v.exp_mem, v.exp_pc});
        @(negedge clk);
        bus.imem_ready = 1'b0;
        check({tag, "_instr_q"}, 32'(bus.instr_q), 32'(v.instr));
        guard = 0;
        dcyc  = 0;
        got   = 1'b0;
        while (guard < 50 && !got) begin
            if (bus.dmem_req) begin
                dcyc++;
                bus.dmem_ready = (dcyc > v.dmem_wait);
                #1;
            end
            if (bus.exec_en) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_commit_timeout got=none want=exec_en", tag);
            void'(exp_q.pop_front());
            bus.dmem_ready = 1'b0;
        end else begin
            e = exp_q.pop_front();
            exp_retired++;
            if (v.exp_taken) exp_taken_cnt++;
            check({tag, "_taken"}, 32'(bus.branch_taken), 32'(e[33]));
            check({tag, "_mem"}, 32'(bus.dmem_req), 32'(e[32]));
            check({tag, "_dmem_cycles"}, 32'(dcyc), v.exp_mem ? 32'(v.dmem_wait + 1) : 32'd0);
            @(negedge clk);
            bus.dmem_ready = 1'b0;
            check({tag, "_pc"}, bus.pc, e[31:0]);
            check({tag, "_exec_pulse"}, 32'(bus.exec_en), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t hv;
        logic [31:0] frozen_pc;
        bit halt_bad;

        vecs[0]  = '{16'hE005, 5'd0,  4'hE, 32'h005, 4'b0000, 0, 32'h0000_0010, 1'b1, 1'b0};
        vecs[1]  = '{16'hD0FE, 5'd0,  4'h0, 32'h0FE, 4'b0100, 0, 32'h0000_0010, 1'b1, 1'b0};
        vecs[2]  = '{16'hD0FE, 5'd0,  4'h0, 32'h0FE, 4'b0000, 0, 32'h0000_0012, 1'b0, 1'b0};
        vecs[3]  = '{16'hE005, 5'd0,  4'hE, 32'h005, 4'b0000, 0, 32'h0000_0020, 1'b1, 1'b0};
        vecs[4]  = '{16'hE7FE, 5'd0,  4'hE, 32'h7FE, 4'b0000, 0, 32'h0000_0020, 1'b1, 1'b0};
        vecs[5]  = '{16'hE7EE, 5'd0,  4'hE, 32'h7EE, 4'b0000, 0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6]  = '{16'hE3FF, 5'd0,  4'hE, 32'h3FF, 4'b0000, 0, 32'h0000_0802, 1'b1, 1'b0};
        vecs[7]  = '{16'hD1FE, 5'd0,  4'h1, 32'h0FE, 4'b0100, 0, 32'h0000_0804, 1'b0, 1'b0};
        vecs[8]  = '{16'hDA02, 5'd0,  4'hA, 32'h002, 4'b1001, 0, 32'h0000_080C, 1'b1, 1'b0};
        vecs[9]  = '{16'hDB80, 5'd0,  4'hB, 32'h080, 4'b1000, 0, 32'h0000_0710, 1'b1, 1'b0};
        vecs[10] = '{16'hD810, 5'd0,  4'h8, 32'h010, 4'b0110, 0, 32'h0000_0712, 1'b0, 1'b0};
        vecs[11] = '{16'hD910, 5'd0,  4'h9, 32'h010, 4'b0110, 0, 32'h0000_0736, 1'b1, 1'b0};
        vecs[12] = '{16'hDC01, 5'd0,  4'hC, 32'h001, 4'b0000, 0, 32'h0000_073C, 1'b1, 1'b0};
        vecs[13] = '{16'hDD01, 5'd0,  4'hD, 32'h001, 4'b0000, 0, 32'h0000_073E, 1'b0, 1'b0};
        vecs[14] = '{16'h6800, 5'd10, 4'hF, 32'h000, 4'b1111, 3, 32'h0000_0740, 1'b0, 1'b1};
        vecs[15] = '{16'h6000, 5'd9,  4'hF, 32'h000, 4'b1111, 0, 32'h0000_0742, 1'b0, 1'b1};
        vecs[16] = '{16'h0000, 5'd0,  4'hF, 32'h000, 4'b1111, 0, 32'h0000_0744, 1'b0, 1'b0};

        reset           = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.uop         = 5'd0;
        bus.branch_cond = COND_NONE;
        bus.num         = 32'd0;
        bus.explose     = 1'b0;
        bus.nzcv        = 4'b0000;
        bus.dmem_ready  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_pc", bus.pc, 32'h0);
        check("rst_instr_q", 32'(bus.instr_q), 32'h0);
        check("rst_exec_en", 32'(bus.exec_en), 32'd0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("rst_branch_taken", 32'(bus.branch_taken), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_FETCH));

        // First instruction with imem always ready: commit lands in the third cycle.
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 16'h1888;
        bus.uop        = 5'd1;
        reset          = 1'b0;
        @(negedge clk);
        check("t1_c2_exec_en", 32'(bus.exec_en), 32'd0);
        check("t1_c2_state", 32'(bus.dbg_state), 32'(ST_DECODE));
        check("t1_instr_q", 32'(bus.instr_q), 32'h1888);
        @(negedge clk);
        check("t1_c3_exec_en", 32'(bus.exec_en), 32'd1);
        check("t1_c3_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("t1_c3_taken", 32'(bus.branch_taken), 32'd0);
        bus.imem_ready = 1'b0;
        exp_retired++;
        @(negedge clk);
        check("t1_pc", bus.pc, 32'h2);
        check("t1_exec_done", 32'(bus.exec_en), 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef SEQ_PERF_EN
        check("perf_retired", perf_retired, 32'(exp_retired));
        check("perf_taken", perf_taken, 32'(exp_taken_cnt));
`endif

        // Negative 11-bit offset from pc 0 wraps below zero.
        pulse_reset();
        check("rst2_pc", bus.pc, 32'h0);
        hv = '{16'hE400, 5'd0, 4'hE, 32'h400, 4'b0000, 0, 32'hFFFF_F804, 1'b1, 1'b0};
        run_vec(hv, "wrap");

        // Illegal instruction: sticky halt, every strobe quiet, pc frozen.
        frozen_pc = bus.pc;
        wait_fetch();
        bus.imem_rdata  = 16'hDEAD;
        bus.uop         = 5'd0;
        bus.branch_cond = COND_AL;
        bus.num         = 32'h0000_0010;
        bus.explose     = 1'b1;
        bus.imem_ready  = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        @(negedge clk);
        check("halt_state", 32'(bus.dbg_state), 32'(ST_HALT));
        check("halt_flag", 32'(bus.halted), 32'd1);
        halt_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.dmem_ready = 1'($urandom_range(0, 1));
            bus.explose    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.imem_req || bus.exec_en || bus.dmem_req || bus.branch_taken ||
                !bus.halted || bus.pc !== frozen_pc)
                halt_bad = 1'b1;
        end
        check("halt_quiet_20", 32'(halt_bad), 32'd0);
        check("halt_pc_frozen", bus.pc, 32'hFFFF_F804);
`ifdef SEQ_PERF_EN
        check("halt_perf_retired", perf_retired, 32'(exp_retired));
        check("halt_perf_taken", perf_taken, 32'(exp_taken_cnt));
`endif
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.explose    = 1'b0;
        pulse_reset();
        check("recover_pc", bus.pc, 32'h0);
        check("recover_halted", 32'(bus.halted), 32'd0);
        check("recover_state", 32'(bus.dbg_state), 32'(ST_FETCH));

        // Reset landing mid-access must drop dmem_req without waiting for a clock edge.
        hv = '{16'hE3FF, 5'd0, 4'hE, 32'h3FF, 4'b0000, 0, 32'h0000_0802, 1'b1, 1'b0};
        run_vec(hv, "pre_mem");
        wait_fetch();
        bus.imem_rdata  = 16'h6800;
        bus.uop         = UOP_LDR;
        bus.branch_cond = COND_NONE;
        bus.imem_ready  = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        @(negedge clk);
        check("mem_state", 32'(bus.dbg_state), 32'(ST_MEM));
        check("mem_req_high", 32'(bus.dmem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mem_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("mem_rst_state", 32'(bus.dbg_state), 32'(ST_FETCH));
        check("mem_rst_pc", bus.pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
